// File: rtl/ppcmd_fetch_if.sv
// Bundle of the fetch engine's control, memory port-B and command-stream signals.
// The engine itself uses the master view; the host/sequencer/memory side uses the slave view.
interface ppcmd_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              stop;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              busy;
  logic              wrapped;

  modport master (
    input  start, start_addr, stop, jump, jump_addr, mem_dout, cmd_ready,
    output mem_addr, mem_en, cmd_data, cmd_addr, cmd_valid, busy, wrapped
  );

  modport slave (
    output start, start_addr, stop, jump, jump_addr, mem_dout, cmd_ready,
    input  mem_addr, mem_en, cmd_data, cmd_addr, cmd_valid, busy, wrapped
  );
endinterface

// File: rtl/ppcmd_fetch.sv
// Sequential read engine for pulse-program command memory port B: issues reads,
// tracks in-flight addresses and buffers returned words in a first-word-fall-through FIFO.
module ppcmd_fetch #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clk,
  input logic           rst_n,
  ppcmd_fetch_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]       tgt_q, tgt_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic                    mem_en_q, mem_en_d;
  logic                    wrapped_q, wrapped_d;
  logic                    halt_q, halt_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]       tag_q [READ_LATENCY];
  logic [ADDR_W-1:0]       tag_d [READ_LATENCY];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d, occupancy;
  logic [DATA_W-1:0]       fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]       fifo_addr_q [FIFO_DEPTH];

  logic              flush, load, issue, pop, push, cmd_valid;
  logic [ADDR_W-1:0] base;

  assign cmd_valid = (count_q != '0);
  assign pop       = cmd_valid & bus.cmd_ready;
  assign push      = vld_q[READ_LATENCY-1] & ~flush;

  // Control: state transitions, issue decision and address pointer.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    wrapped_d  = wrapped_q;
    halt_d     = halt_q;
    flush      = 1'b0;
    load       = 1'b0;
    base       = ptr_q;
    ptr_d      = ptr_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d   = S_FETCH;
          base      = bus.start_addr;
          load      = 1'b1;
          wrapped_d = 1'b0;
        end
      end
      S_FETCH, S_FLUSH: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (bus.jump) begin
          state_d = S_FLUSH;
          tgt_d   = bus.jump_addr;
          flush   = 1'b1;
        end else if (bus.start) begin
          state_d   = S_FLUSH;
          tgt_d     = bus.start_addr;
          wrapped_d = 1'b0;
          flush     = 1'b1;
        end else if (state_q == S_FLUSH) begin
          state_d = S_FETCH;
          base    = tgt_q;
          load    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      halt_d = 1'b0;
      ptr_d  = base;
    end

    // Words already owed to the FIFO: buffered, being sampled by memory, or in the pipe.
    occupancy = count_q + CNT_W'(mem_en_q) - CNT_W'(pop);
    for (int i = 0; i < READ_LATENCY; i++) begin
      occupancy = occupancy + CNT_W'(vld_q[i]);
    end

    issue = (state_d == S_FETCH) && !halt_d && !flush && (occupancy < CNT_W'(FIFO_DEPTH));
    if (issue) begin
      mem_addr_d = base;
      ptr_d      = base + ADDR_W'(1);
      if (&base) begin
        halt_d    = 1'b1;
        wrapped_d = 1'b1;
      end
    end
    mem_en_d = issue;
  end

  // Read-return tracking and FIFO bookkeeping; a flush discards everything outstanding.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = mem_en_q & ~flush;
    tag_d[0] = mem_addr_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1] & ~flush;
      tag_d[i] = tag_q[i-1];
    end
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      tgt_q      <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      wrapped_q  <= 1'b0;
      halt_q     <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tgt_q      <= tgt_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      wrapped_q  <= wrapped_d;
      halt_q     <= halt_d;
      vld_q      <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= tag_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.mem_dout;
      fifo_addr_q[wr_ptr_q] <= tag_q[READ_LATENCY-1];
    end
  end

  // Head word is masked when empty so the outputs read zero out of reset.
  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_data  = cmd_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.cmd_addr  = cmd_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_FLUSH);
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_ppcmd_fetch.sv
// Directed scoreboard bench for ppcmd_fetch: one instance at read latency 1,
// one at read latency 2, each behind its own behavioural port-B memory.
module tb_ppcmd_fetch;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int K_START = 0;
  localparam int K_JUMP  = 1;
  localparam int K_STOP  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppcmd_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) a ();
  ppcmd_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

  ppcmd_fetch #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  ppcmd_fetch #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  // Behavioural port-B memories: one and two register stages.
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] a_dout, b_s1, b_dout;
  always @(posedge clk) if (a.mem_en) a_dout <= mem[a.mem_addr];
  always @(posedge clk) begin
    if (b.mem_en) b_s1 <= mem[b.mem_addr];
    b_dout <= b_s1;
  end
  assign a.mem_dout = a_dout;
  assign b.mem_dout = b_dout;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int rd0_cnt = 0;
  int valid_b_cnt = 0;
  int stray_a = 0;
  int stray_b = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle command pulse; start/jump replace the expected word stream.
  task automatic applyStimulus(input bit on_b, input int kind, input logic [AW-1:0] addr, input int n);
    exp_t e;
    if (!on_b) begin
      if (kind == K_START) begin a.start = 1'b1; a.start_addr = addr; end
      if (kind == K_JUMP)  begin a.jump  = 1'b1; a.jump_addr  = addr; end
      if (kind == K_STOP)  a.stop = 1'b1;
    end else begin
      if (kind == K_START) begin b.start = 1'b1; b.start_addr = addr; end
      if (kind == K_JUMP)  begin b.jump  = 1'b1; b.jump_addr  = addr; end
      if (kind == K_STOP)  b.stop = 1'b1;
    end
    if (kind != K_STOP) begin
      if (on_b) qb.delete(); else qa.delete();
      for (int i = 0; i < n; i++) begin
        e.addr = AW'(addr + i);
        e.data = mem[e.addr];
        if (on_b) qb.push_back(e); else qa.push_back(e);
      end
    end
  endtask

  // One clock: score words accepted at the coming edge, then observe after it.
  task automatic clockStep();
    exp_t e;
    if (a.cmd_valid && a.cmd_ready) begin
      if (qa.size() == 0) stray_a++;
      else begin
        e = qa.pop_front();
        checkOutput("a_cmd_data", a.cmd_data, e.data);
        checkOutput("a_cmd_addr", a.cmd_addr, e.addr);
      end
    end
    if (b.cmd_valid && b.cmd_ready) begin
      if (qb.size() == 0) stray_b++;
      else begin
        e = qb.pop_front();
        checkOutput("b_cmd_data", b.cmd_data, e.data);
        checkOutput("b_cmd_addr", b.cmd_addr, e.addr);
      end
    end
    @(posedge clk);
    #1;
    a.start = 1'b0; a.stop = 1'b0; a.jump = 1'b0;
    b.start = 1'b0; b.stop = 1'b0; b.jump = 1'b0;
    if (a.mem_en) begin
      en_cnt++;
      if (a.mem_addr == '0) rd0_cnt++;
    end
    if (b.cmd_valid) valid_b_cnt++;
  endtask

  initial begin
    int ticks;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0000_0123;
    mem[1] = 32'h0000_4567;
    for (int i = 2; i < 8; i++) mem[i] = 32'h100 + i;

    a.start = 0; a.start_addr = '0; a.stop = 0; a.jump = 0; a.jump_addr = '0; a.cmd_ready = 0;
    b.start = 0; b.start_addr = '0; b.stop = 0; b.jump = 0; b.jump_addr = '0; b.cmd_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_valid", a.cmd_valid, 0);
    checkOutput("rst_mem_en", a.mem_en, 0);
    checkOutput("rst_busy", a.busy, 0);
    checkOutput("rst_wrapped", a.wrapped, 0);
    checkOutput("rst_cmd_data", a.cmd_data, 0);
    checkOutput("rst_b_cmd_valid", b.cmd_valid, 0);
    rst_n = 1'b1;
    clockStep();

    // Basic stream with cmd_ready held high.
    a.cmd_ready = 1'b1;
    applyStimulus(0, K_START, 12'h000, 8);
    clockStep();
    checkOutput("t1_mem_en_e0", a.mem_en, 1);
    checkOutput("t1_mem_addr_e0", a.mem_addr, 0);
    checkOutput("t1_busy", a.busy, 1);
    clockStep();
    checkOutput("t1_valid_e1", a.cmd_valid, 0);
    clockStep();
    checkOutput("t1_valid_e2", a.cmd_valid, 1);
    ticks = 0;
    while (qa.size() > 0 && ticks < 30) begin clockStep(); ticks++; end
    checkOutput("t1_stream_cycles", ticks, 8);
    a.cmd_ready = 1'b0;
    applyStimulus(0, K_STOP, '0, 0);
    clockStep();
    checkOutput("t1_stop_valid", a.cmd_valid, 0);
    checkOutput("t1_stop_busy", a.busy, 0);
    en_cnt = 0;
    repeat (3) clockStep();
    checkOutput("t1_idle_mem_en", en_cnt, 0);

    // Backpressure: FIFO fills to depth then issue stops.
    en_cnt = 0;
    applyStimulus(0, K_START, 12'h000, 6);
    repeat (10) clockStep();
    checkOutput("t2_mem_en_pulses", en_cnt, 4);
    checkOutput("t2_valid_held", a.cmd_valid, 1);
    checkOutput("t2_data_held", a.cmd_data, mem[0]);
    a.cmd_ready = 1'b1;
    ticks = 0;
    while (qa.size() > 0 && ticks < 20) begin clockStep(); ticks++; end
    checkOutput("t2_drained", qa.size(), 0);
    a.cmd_ready = 1'b0;
    applyStimulus(0, K_STOP, '0, 0);
    clockStep();

    // Jump with three words buffered and one read in flight.
    applyStimulus(0, K_START, 12'h000, 0);
    repeat (5) clockStep();
    checkOutput("t3_fifo_nonempty", a.cmd_valid, 1);
    applyStimulus(0, K_JUMP, 12'h040, 4);
    clockStep();
    checkOutput("t3_valid_after_jump", a.cmd_valid, 0);
    checkOutput("t3_flush_no_issue", a.mem_en, 0);
    clockStep();
    checkOutput("t3_mem_en_target", a.mem_en, 1);
    checkOutput("t3_mem_addr_target", a.mem_addr, 12'h040);
    a.cmd_ready = 1'b1;
    clockStep();
    checkOutput("t3_valid_e2", a.cmd_valid, 0);
    clockStep();
    checkOutput("t3_valid_e3", a.cmd_valid, 1);
    ticks = 0;
    while (qa.size() > 0 && ticks < 20) begin clockStep(); ticks++; end
    checkOutput("t3_drained", qa.size(), 0);
    a.cmd_ready = 1'b0;
    applyStimulus(0, K_STOP, '0, 0);
    clockStep();

    // Stop and jump together with a pop in the same cycle.
    applyStimulus(0, K_START, 12'h020, 1);
    repeat (3) clockStep();
    checkOutput("t4_valid", a.cmd_valid, 1);
    a.cmd_ready = 1'b1;
    applyStimulus(0, K_STOP, '0, 0);
    a.jump = 1'b1;
    a.jump_addr = 12'h050;
    clockStep();
    checkOutput("t4_popped", qa.size(), 0);
    checkOutput("t4_valid_after", a.cmd_valid, 0);
    checkOutput("t4_busy_after", a.busy, 0);
    checkOutput("t4_mem_en_after", a.mem_en, 0);
    en_cnt = 0;
    repeat (5) clockStep();
    checkOutput("t4_no_issue", en_cnt, 0);
    checkOutput("t4_stray_words", stray_a, 0);

    // Wrap at the top of the address space.
    rd0_cnt = 0;
    applyStimulus(0, K_START, 12'hFFE, 2);
    ticks = 0;
    while (qa.size() > 0 && ticks < 20) begin clockStep(); ticks++; end
    checkOutput("t5_drained", qa.size(), 0);
    repeat (5) clockStep();
    checkOutput("t5_wrapped", a.wrapped, 1);
    checkOutput("t5_no_read_0", rd0_cnt, 0);
    checkOutput("t5_busy", a.busy, 1);
    checkOutput("t5_valid", a.cmd_valid, 0);
    checkOutput("t5_stray_words", stray_a, 0);
    a.cmd_ready = 1'b0;
    applyStimulus(0, K_START, 12'h000, 0);
    clockStep();
    checkOutput("t5_wrap_cleared", a.wrapped, 0);
    applyStimulus(0, K_STOP, '0, 0);
    clockStep();

    // Read latency 2, then asynchronous reset mid-stream.
    b.cmd_ready = 1'b1;
    applyStimulus(1, K_START, 12'h000, 8);
    repeat (3) clockStep();
    checkOutput("t6_valid_e2", b.cmd_valid, 0);
    clockStep();
    checkOutput("t6_valid_e3", b.cmd_valid, 1);
    repeat (2) clockStep();
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", b.cmd_valid, 0);
    checkOutput("t6_rst_mem_en", b.mem_en, 0);
    checkOutput("t6_rst_busy", b.busy, 0);
    checkOutput("t6_rst_cmd_data", b.cmd_data, 0);
    qb.delete();
    repeat (2) clockStep();
    rst_n = 1'b1;
    valid_b_cnt = 0;
    repeat (8) clockStep();
    checkOutput("t6_no_valid_after_release", valid_b_cnt, 0);
    checkOutput("t6_stray_words", stray_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ppcmd_fetch.md
Name: ppcmd_fetch

Overview:
- Read-side engine for the pulse-program command memory (ppcmdmem) port B: 32-bit words, 4096 deep.
- Host loads commands through port A; this block fetches them sequentially from port B starting at a programmed address.
- Buffers fetched words in a small prefetch FIFO and presents them to the pulse sequencer over a valid/ready handshake.
- Supports jump (flush and refetch) and stop; one clock domain, the port-B clock.

Parameters:
ADDR_W, 12, port-B word address width
DATA_W, 32, command word width
READ_LATENCY, 1, edges from memory sampling mem_addr/mem_en to mem_dout valid (supported 1 or 2)
FIFO_DEPTH, 4, prefetch FIFO depth in words (power of two, at least READ_LATENCY+2)

Ports:
clk  in  1  port-B memory clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin fetching at start_addr
start_addr  in  ADDR_W  first word address
stop  in  1  one-cycle pulse; halt, flush FIFO and in-flight reads
jump  in  1  one-cycle pulse; flush, resume fetching at jump_addr
jump_addr  in  ADDR_W  jump target
mem_addr  out  ADDR_W  port-B address (web tied 0 at top level)
mem_en  out  1  port-B read enable
mem_dout  in  DATA_W  port-B read data
cmd_data  out  DATA_W  head-of-FIFO command word
cmd_addr  out  ADDR_W  memory address cmd_data was read from
cmd_valid  out  1  cmd_data valid
cmd_ready  in  1  sequencer accepts word when cmd_valid & cmd_ready
busy  out  1  state is FETCH or FLUSH
wrapped  out  1  sticky; address passed 2^ADDR_W-1

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, state IDLE, in-flight tags cleared, wrapped 0.
- States:
  - IDLE: start -> FETCH, issue pointer = start_addr, wrapped cleared.
  - FETCH: issue reads; stop -> IDLE; jump -> FLUSH.
  - FLUSH: one cycle, no issue; then -> FETCH at jump_addr.
- Issue rule: mem_en=1 in a cycle iff FETCH and (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = cmd_valid & cmd_ready this cycle. mem_addr = issue pointer, registered; pointer increments after each issue.
- Inflight tracked by a READ_LATENCY-long valid shift register, each entry tagged with its address. A tag reaching the end writes mem_dout and the tag address into the FIFO.
- Latency (READ_LATENCY=1): start sampled at edge E0; after E0 mem_en=1, mem_addr=start_addr; after E2 cmd_valid=1 with M[start_addr]. Each extra READ_LATENCY adds one cycle.
- Throughput: sustained 1 word/clk while cmd_ready held high; FIFO never overflows.
- FIFO is first-word-fall-through; cmd_data/cmd_addr stable while cmd_valid & !cmd_ready.
- stop or jump: same-cycle pop is honoured. FIFO is then emptied and all in-flight tags invalidated at that edge. Memory data returning afterwards is discarded. cmd_valid is 0 the next cycle.
- After jump, first word at jump_addr arrives no earlier than 1 cycle later than the equivalent start latency.
- Simultaneous events: stop has priority over jump and start. jump has priority over start. start in FETCH is treated as jump to start_addr. jump in IDLE is ignored.
- Wrap: issuing at address 2^ADDR_W-1 sets wrapped and stops issuing (remains FETCH). Buffered and in-flight words still drain. Cleared only by start or reset.
- stop in IDLE: no effect.
- Reset mid-fetch: everything cleared immediately; late mem_dout ignored.

Test Plan:
- Preload M[0]=0x00000123, M[1]=0x00004567, M[2..7]=0x100+i. Pulse start with start_addr=0 and cmd_ready=1 -> cmd_valid rises 2 cycles after start; cmd_data sequence 0x123, 0x4567, 0x102… on consecutive cycles; cmd_addr 0,1,2…
- Backpressure: cmd_ready=0 for 10 cycles after start -> mem_en pulses exactly FIFO_DEPTH (4) times, then 0. cmd_data held at 0x123. On release, in-order delivery with no loss or duplicate.
- Jump: jump_addr=0x040 while FIFO holds 3 words and 1 read is in flight -> next cmd_valid word is M[0x040], cmd_addr=0x040; no stale words delivered.
- Stop with simultaneous pop and jump -> popped word consumed. Next cycle: cmd_valid=0, busy=0, no further mem_en.
- Wrap: start_addr=0xFFE, cmd_ready=1 -> words at 0xFFE and 0xFFF delivered; wrapped=1; no read of 0x000.
- Async reset asserted mid-stream with READ_LATENCY=2 -> outputs 0 immediately; no cmd_valid after release until a new start.
